// File: rtl/ysyx_22041211_wb_unit_pkg.sv
// Shared constants and the FSM next-state function for the write-back unit.
package ysyx_22041211_wb_unit_pkg;

  // State encodings. Plain constants keep the encoding fixed for existing consumers.
  localparam logic [1:0] WB_IDLE  = 2'b00;
  localparam logic [1:0] WB_WRITE = 2'b01;
  localparam logic [1:0] WB_DONE  = 2'b10;

  // Index of the hard-wired zero register.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // IDLE -> WRITE -> DONE -> IDLE. WRITE always lasts one cycle. The one
  // unused encoding recovers to IDLE.
  function automatic logic [1:0] wb_next_state(input logic [1:0] state,
                                               input logic       accept,
                                               input logic       commit);
    logic [1:0] nxt;
    nxt = WB_IDLE;
    case (state)
      WB_IDLE:  nxt = accept ? WB_WRITE : WB_IDLE;
      WB_WRITE: nxt = WB_DONE;
      WB_DONE:  nxt = commit ? WB_IDLE : WB_DONE;
      default:  nxt = WB_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_22041211_retire_counter.sv
// Free-running retired-instruction counter. It wraps silently at its full width.
module ysyx_22041211_retire_counter
  import ysyx_22041211_wb_unit_pkg::*;
#(
  parameter int CNT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [CNT_LEN-1:0] cnt
);

  logic [CNT_LEN-1:0] cnt_q;
  logic [CNT_LEN-1:0] cnt_d;

  // Next count: add one on each commit handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_LEN'(1);
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_22041211_wb_unit.sv
// Write-back stage. It takes one LSU result, pulses the GPR/CSR write strobes for
// one cycle, then holds commit valid until the IFU accepts it.
module ysyx_22041211_wb_unit
  import ysyx_22041211_wb_unit_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int REG_ADDR = 5,
  parameter int CSR_ADDR = 12,
  parameter int CNT_LEN  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid_i,
  output logic                wb_ready_o,
  input  logic                wd_i,
  input  logic [REG_ADDR-1:0] wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic                csr_wen_i,
  input  logic [CSR_ADDR-1:0] csr_addr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  output logic                reg_wen_o,
  output logic [REG_ADDR-1:0] reg_waddr_o,
  output logic [DATA_LEN-1:0] reg_wdata_o,
  output logic                csr_wen_o,
  output logic [CSR_ADDR-1:0] csr_waddr_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                wb_valid_o,
  input  logic                ifu_ready_i,
  output logic [CNT_LEN-1:0]  retire_cnt_o
);

  // Result captured at accept time and held until the next accept.
  typedef struct packed {
    logic                wd;
    logic [REG_ADDR-1:0] wreg;
    logic [DATA_LEN-1:0] wdata;
    logic                csr_wen;
    logic [CSR_ADDR-1:0] csr_addr;
    logic [DATA_LEN-1:0] csr_wdata;
  } cap_t;

  logic [1:0] state_q;
  logic [1:0] state_d;
  cap_t       cap_q;
  cap_t       cap_d;
  logic       accept;
  logic       commit;
  logic       in_write;

  // Both handshakes decode the registered state only.
  assign accept   = lsu_valid_i & (state_q == WB_IDLE);
  assign commit   = ifu_ready_i & (state_q == WB_DONE);
  assign in_write = (state_q == WB_WRITE);

  // Next state and next capture value.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    state_d = wb_next_state(state_q, accept, commit);
    cap_d   = cap_q;
    if (accept) begin
      cap_d.wd        = wd_i;
      cap_d.wreg      = wreg_i;
      cap_d.wdata     = wdata_i;
      cap_d.csr_wen   = csr_wen_i;
      cap_d.csr_addr  = csr_addr_i;
      cap_d.csr_wdata = csr_wdata_i;
    end
  end

  // State and capture registers. Reset drops any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      cap_q   <= '0;
    end else begin
      // NOTE: non-blocking updates let every register sample the pre-edge values, with no ordering races between blocks.
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Strobes fire only in WRITE. A GPR write to x0 is suppressed.
  assign reg_wen_o   = in_write & cap_q.wd & (cap_q.wreg != REG_ADDR'(REG_ZERO));
  assign csr_wen_o   = in_write & cap_q.csr_wen;
  assign reg_waddr_o = cap_q.wreg;
  assign reg_wdata_o = cap_q.wdata;
  assign csr_waddr_o = cap_q.csr_addr;
  assign csr_wdata_o = cap_q.csr_wdata;
  assign wb_ready_o  = (state_q == WB_IDLE);
  assign wb_valid_o  = (state_q == WB_DONE);

  ysyx_22041211_retire_counter #(
    .CNT_LEN (CNT_LEN)
  ) u_retire_counter (
    .clk (clk),
    .rst (rst),
    .inc (commit),
    .cnt (retire_cnt_o)
  );

endmodule

// File: tb/tb_ysyx_22041211_wb_unit.sv
// Directed bench for the write-back unit. A second copy with a 2-bit retire
// counter runs in lockstep on the same stimulus to exercise counter wrap-around.
module tb_ysyx_22041211_wb_unit;

  logic        clk;
  logic        rst;
  logic        lsu_valid_i;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] wdata_i;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        ifu_ready_i;

  logic        wb_ready_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        wb_valid_o;
  logic [63:0] retire_cnt_o;

  logic        s_wb_ready;
  logic        s_reg_wen;
  logic [4:0]  s_reg_waddr;
  logic [31:0] s_reg_wdata;
  logic        s_csr_wen;
  logic [11:0] s_csr_waddr;
  logic [31:0] s_csr_wdata;
  logic        s_wb_valid;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_22041211_wb_unit dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid_i  (lsu_valid_i),
    .wb_ready_o   (wb_ready_o),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .csr_wen_i    (csr_wen_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .reg_wen_o    (reg_wen_o),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o),
    .csr_wen_o    (csr_wen_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .wb_valid_o   (wb_valid_o),
    .ifu_ready_i  (ifu_ready_i),
    .retire_cnt_o (retire_cnt_o)
  );

  ysyx_22041211_wb_unit #(.CNT_LEN(2)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid_i  (lsu_valid_i),
    .wb_ready_o   (s_wb_ready),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .csr_wen_i    (csr_wen_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .reg_wen_o    (s_reg_wen),
    .reg_waddr_o  (s_reg_waddr),
    .reg_wdata_o  (s_reg_wdata),
    .csr_wen_o    (s_csr_wen),
    .csr_waddr_o  (s_csr_waddr),
    .csr_wdata_o  (s_csr_wdata),
    .wb_valid_o   (s_wb_valid),
    .ifu_ready_i  (ifu_ready_i),
    .retire_cnt_o (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a result to the LSU port.
  task automatic drive(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic cwen, input logic [11:0] caddr, input logic [31:0] cdata);
    lsu_valid_i = 1'b1;
    wd_i        = wd;
    wreg_i      = wreg;
    wdata_i     = wdata;
    csr_wen_i   = cwen;
    csr_addr_i  = caddr;
    csr_wdata_i = cdata;
  endtask

  initial begin
    rst         = 1'b1;
    lsu_valid_i = 1'b0;
    wd_i        = 1'b0;
    wreg_i      = '0;
    wdata_i     = '0;
    csr_wen_i   = 1'b0;
    csr_addr_i  = '0;
    csr_wdata_i = '0;
    ifu_ready_i = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready",   64'(wb_ready_o),   64'd1);
    check("rst_valid",   64'(wb_valid_o),   64'd0);
    check("rst_reg_wen", 64'(reg_wen_o),    64'd0);
    check("rst_csr_wen", 64'(csr_wen_o),    64'd0);
    check("rst_waddr",   64'(reg_waddr_o),  64'd0);
    check("rst_wdata",   64'(reg_wdata_o),  64'd0);
    check("rst_cnt",     retire_cnt_o,      64'd0);
    rst = 1'b0;

    // 1: plain GPR write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'h000, 32'h0);
    step();
    lsu_valid_i = 1'b0;
    check("t1_reg_wen", 64'(reg_wen_o),   64'd1);
    check("t1_waddr",   64'(reg_waddr_o), 64'd5);
    check("t1_wdata",   64'(reg_wdata_o), 64'hDEADBEEF);
    check("t1_csr_wen", 64'(csr_wen_o),   64'd0);
    check("t1_ready",   64'(wb_ready_o),  64'd0);
    check("t1_valid_w", 64'(wb_valid_o),  64'd0);
    step();
    check("t1_reg_wen_off", 64'(reg_wen_o),  64'd0);
    check("t1_valid",       64'(wb_valid_o), 64'd1);
    check("t1_cnt_before",  retire_cnt_o,    64'd0);
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i = 1'b0;
    check("t1_cnt",        retire_cnt_o,     64'd1);
    check("t1_idle_ready", 64'(wb_ready_o),  64'd1);
    check("t1_idle_valid", 64'(wb_valid_o),  64'd0);
    check("t1_hold_waddr", 64'(reg_waddr_o), 64'd5);

    // 2: write to x0 is suppressed but still retires
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 12'h000, 32'h0);
    step();
    lsu_valid_i = 1'b0;
    check("t2_reg_wen", 64'(reg_wen_o),   64'd0);
    check("t2_wdata",   64'(reg_wdata_o), 64'h12345678);
    step();
    check("t2_valid", 64'(wb_valid_o), 64'd1);
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i = 1'b0;
    check("t2_cnt", retire_cnt_o, 64'd2);

    // 3: GPR and CSR written in the same cycle
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 12'h305, 32'h80000000);
    step();
    lsu_valid_i = 1'b0;
    check("t3_reg_wen", 64'(reg_wen_o),   64'd1);
    check("t3_csr_wen", 64'(csr_wen_o),   64'd1);
    check("t3_waddr",   64'(reg_waddr_o), 64'd3);
    check("t3_wdata",   64'(reg_wdata_o), 64'hA5A5A5A5);
    check("t3_caddr",   64'(csr_waddr_o), 64'h305);
    check("t3_cdata",   64'(csr_wdata_o), 64'h80000000);
    step();
    check("t3_reg_wen_off", 64'(reg_wen_o), 64'd0);
    check("t3_csr_wen_off", 64'(csr_wen_o), 64'd0);

    // 4: stalled in DONE with a new result offered
    drive(1'b1, 5'd7, 32'h11111111, 1'b1, 12'h300, 32'h22222222);
    for (int i = 0; i < 10; i++) begin
      check("t4_valid", 64'(wb_valid_o),  64'd1);
      check("t4_ready", 64'(wb_ready_o),  64'd0);
      check("t4_rwen",  64'(reg_wen_o),   64'd0);
      check("t4_cwen",  64'(csr_wen_o),   64'd0);
      check("t4_waddr", 64'(reg_waddr_o), 64'd3);
      check("t4_caddr", 64'(csr_waddr_o), 64'h305);
      step();
    end
    check("t4_cnt_stall", retire_cnt_o, 64'd2);
    // lsu_valid high across DONE->IDLE is not taken on that edge
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i = 1'b0;
    check("t4_cnt",       retire_cnt_o,     64'd3);
    check("t4_small_cnt", 64'(s_cnt),       64'd3);
    check("t4_idle",      64'(wb_ready_o),  64'd1);
    check("t4_no_write",  64'(reg_wen_o),   64'd0);
    check("t4_old_waddr", 64'(reg_waddr_o), 64'd3);
    step();
    lsu_valid_i = 1'b0;
    check("t4_late_rwen",  64'(reg_wen_o),   64'd1);
    check("t4_late_waddr", 64'(reg_waddr_o), 64'd7);
    check("t4_late_cwen",  64'(csr_wen_o),   64'd1);
    check("t4_late_caddr", 64'(csr_waddr_o), 64'h300);
    check("t4_late_cdata", 64'(csr_wdata_o), 64'h22222222);
    step();
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i = 1'b0;

    // 6: counter wrap in the narrow instance (3 -> 0), no other side effects
    check("t6_cnt",        retire_cnt_o,    64'd4);
    check("t6_small_wrap", 64'(s_cnt),      64'd0);
    check("t6_small_rdy",  64'(s_wb_ready), 64'd1);
    check("t6_small_val",  64'(s_wb_valid), 64'd0);
    check("t6_small_rwen", 64'(s_reg_wen),  64'd0);

    // 5: reset while in WRITE
    drive(1'b1, 5'd9, 32'h99999999, 1'b0, 12'h000, 32'h0);
    step();
    lsu_valid_i = 1'b0;
    check("t5_in_write", 64'(reg_wen_o), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rwen",  64'(reg_wen_o),   64'd0);
    check("t5_cwen",  64'(csr_wen_o),   64'd0);
    check("t5_ready", 64'(wb_ready_o),  64'd1);
    check("t5_valid", 64'(wb_valid_o),  64'd0);
    check("t5_cnt",   retire_cnt_o,     64'd0);
    check("t5_waddr", 64'(reg_waddr_o), 64'd0);
    step();
    check("t5_no_done", 64'(wb_valid_o), 64'd0);
    rst = 1'b0;
    drive(1'b1, 5'd10, 32'hCAFEF00D, 1'b0, 12'h000, 32'h0);
    step();
    lsu_valid_i = 1'b0;
    check("t5_post_rwen",  64'(reg_wen_o),   64'd1);
    check("t5_post_waddr", 64'(reg_waddr_o), 64'd10);
    check("t5_post_wdata", 64'(reg_wdata_o), 64'hCAFEF00D);
    step();
    check("t5_post_valid", 64'(wb_valid_o), 64'd1);
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i = 1'b0;
    check("t5_post_cnt",   retire_cnt_o, 64'd1);
    check("t5_post_small", 64'(s_cnt),   64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
